rv32i_decode_exec: RTL and testbench
====================================

Name: rv32i_decode_exec

Overview:
- Decode/register-file/execute datapath for the multi-cycle RV32I core (FETCH→DECODE→EXEC→MEM→WRITE).
- Latches a raw instruction word in DECODE, reads operands, and computes the ALU/address/branch result in EXEC.
- Exposes the control flags the core's MEM/WRITE sequencer consumes.
- Accepts a delayed write-back port from the core.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- NREGS, 32, architectural register count

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous reset, active-high (1 clears all state at the next clk edge)
- state  in  3  core phase: FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4, INVALID=7
- instr_raw  in  32  instruction word, valid during DECODE
- pc  in  32  address of the instruction, valid during EXEC
- w_enable  in  1  register write strobe
- w_addr  in  5  write index
- w_data  in  32  write data
- rd, rs1, rs2  out  5 each  decoded register fields
- imm  out  32  sign-extended immediate
- rs1_v, rs2_v  out  32 each  register read values
- mem_funct3  out  3  funct3 of the load/store, used by the core for byte-lane selection
- result  out  32  EXEC result
- mem_read_enabled  out  1  instruction is a load
- mem_write_enabled  out  1  instruction is a store
- reg_write_enabled  out  1  rd must be written
- reg_write_dest  out  5  rd
- is_jump_enabled  out  1  pc must be redirected
- jump_dest  out  32  redirect target
- illegal  out  1  unsupported encoding

Behaviour:
- Reset: all registered outputs are 0 and all 32 registers are 0.
- Decode:
  - Registered on the clk edge while state==DECODE; held otherwise.
  - Extracts rd, rs1, rs2 and funct3.
  - Builds imm per format (I, S, B, U, J) with sign extension from bit 31; R-type imm=0.
- Register file:
  - Reads are combinational on rs1/rs2.
  - Writes are synchronous when w_enable=1 (any state); writes to x0 are ignored, so x0 always reads 0.
  - A write and a read of the same index in the same cycle returns the old value; the new value appears the next cycle.
- Execute:
  - Registered on the clk edge while state==EXEC, so outputs are valid from MEM onward; held otherwise.
  - LUI: result=imm.
  - AUIPC: result=pc+imm.
  - JAL: result=pc+4, jump=1, dest=pc+imm.
  - JALR: result=pc+4, jump=1, dest=(rs1_v+imm)&~1.
  - Branches BEQ/BNE/BLT/BGE/BLTU/BGEU: jump=taken, dest=pc+imm, reg_write=0.
  - Loads LB/LH/LW/LBU/LHU: mem_read=1, result=rs1_v+imm, reg_write=1.
  - Stores SB/SH/SW: mem_write=1, result=rs1_v+imm, reg_write=0.
  - OP-IMM / OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. Shift amount is the low 5 bits; SLT is signed, SLTU unsigned.
  - reg_write_enabled=1 for LUI, AUIPC, JAL, JALR, loads and ALU ops; forced to 0 when rd=0.
  - reg_write_dest=rd.
  - Arithmetic is modulo 2^32.
- Illegal instruction (unknown opcode/funct3/funct7, including FENCE/SYSTEM):
  - illegal=1.
  - mem_read, mem_write, reg_write and jump are all 0.
  - result=0.
- At most one of mem_read/mem_write/jump is set at a time.
- Reset asserted mid-instruction clears every output; the register file is cleared too.

Optional Feature:
- RV32M_MUL_EN defined:
  - MUL, MULH, MULHSU and MULHU (opcode OP, funct7=0000001) are decoded.
  - Result is the low or high 32 bits of the 64-bit product with the per-op signedness; reg_write=1.
  - Registered in the same EXEC cycle.
- Undefined: those encodings are illegal.
- DIV/REM are always illegal.

Decomposition:
- Shared package core_pkg:
  - state encoding constants;
  - opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011);
  - a packed instruction-flag struct.
- One sub-module: regfile_32x32 (2 combinational read ports, 1 synchronous write port, x0 hardwired).

Test Plan:
- Reset, then read rs1=5 → rs1_v=0; all flags 0.
- Write back x1=5 and x2=3.
  - DECODE 0x002081B3 (add x3,x1,x2), EXEC → result=8, reg_write=1, dest=3.
  - Same for 0x40208233 (sub x4,x1,x2) → result=2.
- DECODE 0x00500093 (addi x1,x0,5) → imm=5, rs1=0.
  - EXEC → result=5.
  - DECODE 0x123453B7 (lui x7) → result=0x12345000.
- pc=0x100.
  - DECODE 0x00000463 (beq x0,x0,8) → is_jump=1, jump_dest=0x108, reg_write=0.
  - With x1≠x2, 0x00208463 (beq x1,x2,8) → is_jump=0.
- x1=0x1000; DECODE 0x0040A283 (lw x5,4(x1)) → mem_read=1, result=0x1004, mem_funct3=2, dest=5.
- Write x0=0xFFFFFFFF → rs1_v for x0 stays 0.
  - DECODE 0xFFFFFFFF → illegal=1, all enables 0.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared phase/opcode constants, instruction flags and decode/ALU helpers.
// Imported by rv32i_decode_exec and regfile_32x32.
package core_pkg;

   localparam logic [2:0] ST_FETCH   = 3'd0;
   localparam logic [2:0] ST_DECODE  = 3'd1;
   localparam logic [2:0] ST_EXEC    = 3'd2;
   localparam logic [2:0] ST_MEM     = 3'd3;
   localparam logic [2:0] ST_WRITE   = 3'd4;
   localparam logic [2:0] ST_INVALID = 3'd7;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic illegal;
      logic jump;
      logic reg_write;
      logic mem_write;
      logic mem_read;
   } instr_flags_t;

   function automatic logic [31:0] build_imm(input logic [31:0] ins);
      logic [31:0] imm;
      case (ins[6:0])
         OPC_JALR, OPC_LOAD, OPC_OP_IMM:
            imm = {{20{ins[31]}}, ins[31:20]};
         OPC_STORE:
            imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         OPC_BRANCH:
            imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm = {ins[31:12], 12'b0};
         OPC_JAL:
            imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:
            imm = 32'd0;
      endcase
      return imm;
   endfunction

   // alt selects SUB for funct3=000 and SRA for funct3=101
   function automatic logic [31:0] alu(input logic [2:0] funct3, input logic [31:0] a,
                                       input logic [31:0] b, input logic alt);
      logic [31:0] r;
      case (funct3)
         3'd0:    r = alt ? (a - b) : (a + b);
         3'd1:    r = a << b[4:0];
         3'd2:    r = {31'd0, $signed(a) < $signed(b)};
         3'd3:    r = {31'd0, a < b};
         3'd4:    r = a ^ b;
         3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
         3'd6:    r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/regfile_32x32.sv
// rtl/regfile_32x32.sv - 2 combinational read ports, 1 synchronous write port, x0 reads 0.
module regfile_32x32
   import core_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] regs_q [0:NREGS-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         regs_q[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? '0 : regs_q[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/rv32i_decode_exec.sv
// rtl/rv32i_decode_exec.sv - RV32I decode, register file and execute stage of the multi-cycle core.
// Optional RV32M_MUL_EN adds MUL/MULH/MULHSU/MULHU; DIV/REM stay illegal.
module rv32i_decode_exec
   import core_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [2:0]      state,
   input  logic [31:0]     instr_raw,
   input  logic [XLEN-1:0] pc,
   input  logic            w_enable,
   input  logic [4:0]      w_addr,
   input  logic [XLEN-1:0] w_data,
   output logic [4:0]      rd,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] rs1_v,
   output logic [XLEN-1:0] rs2_v,
   output logic [2:0]      mem_funct3,
   output logic [XLEN-1:0] result,
   output logic            mem_read_enabled,
   output logic            mem_write_enabled,
   output logic            reg_write_enabled,
   output logic [4:0]      reg_write_dest,
   output logic            is_jump_enabled,
   output logic [XLEN-1:0] jump_dest,
   output logic            illegal
);

   logic [31:0]     instr_q;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   instr_flags_t    flags_d, flags_q;
   logic [XLEN-1:0] result_d, result_q;
   logic [XLEN-1:0] dest_d, dest_q;
   logic [4:0]      wdest_q;

   // Rsetting the latched word to 0 decodes as an unknown opcode with imm=0
   always_ff @(posedge clk) begin
      if (rstn)                     instr_q <= '0;
      else if (state == ST_DECODE)  instr_q <= instr_raw;
   end

   assign opcode     = instr_q[6:0];
   assign rd         = instr_q[11:7];
   assign funct3     = instr_q[14:12];
   assign rs1        = instr_q[19:15];
   assign rs2        = instr_q[24:20];
   assign funct7     = instr_q[31:25];
   assign imm        = build_imm(instr_q);
   assign mem_funct3 = funct3;

   regfile_32x32 #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
      .clk    (clk),
      .rst    (rstn),
      .raddr1 (rs1),
      .raddr2 (rs2),
      .rdata1 (rs1_v),
      .rdata2 (rs2_v),
      .we     (w_enable),
      .waddr  (w_addr),
      .wdata  (w_data)
   );

`ifdef RV32M_MUL_EN
   logic [63:0] prod_ss, prod_su, prod_uu;
   assign prod_ss = {{32{rs1_v[31]}}, rs1_v} * {{32{rs2_v[31]}}, rs2_v};
   assign prod_su = {{32{rs1_v[31]}}, rs1_v} * {32'd0, rs2_v};
   assign prod_uu = {32'd0, rs1_v} * {32'd0, rs2_v};
`endif

   always_comb begin
      flags_d  = '0;
      result_d = '0;
      dest_d   = '0;
      case (opcode)
         OPC_LUI: begin
            result_d          = imm;
            flags_d.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            result_d          = pc + imm;
            flags_d.reg_write = 1'b1;
         end
         OPC_JAL: begin
            result_d          = pc + 32'd4;
            dest_d            = pc + imm;
            flags_d.jump      = 1'b1;
            flags_d.reg_write = 1'b1;
         end
         OPC_JALR: begin
            result_d          = pc + 32'd4;
            dest_d            = (rs1_v + imm) & ~32'd1;
            flags_d.jump      = 1'b1;
            flags_d.reg_write = 1'b1;
            flags_d.illegal   = (funct3 != 3'd0);
         end
         OPC_BRANCH: begin
            dest_d = pc + imm;
            case (funct3)
               3'd0:    flags_d.jump = (rs1_v == rs2_v);
               3'd1:    flags_d.jump = (rs1_v != rs2_v);
               3'd4:    flags_d.jump = ($signed(rs1_v) <  $signed(rs2_v));
               3'd5:    flags_d.jump = ($signed(rs1_v) >= $signed(rs2_v));
               3'd6:    flags_d.jump = (rs1_v <  rs2_v);
               3'd7:    flags_d.jump = (rs1_v >= rs2_v);
               default: flags_d.illegal = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            result_d          = rs1_v + imm;
            flags_d.mem_read  = 1'b1;
            flags_d.reg_write = 1'b1;
            flags_d.illegal   = (funct3 == 3'd3) || (funct3 > 3'd5);
         end
         OPC_STORE: begin
            result_d          = rs1_v + imm;
            flags_d.mem_write = 1'b1;
            flags_d.illegal   = (funct3 > 3'd2);
         end
         OPC_OP_IMM: begin
            result_d          = alu(funct3, rs1_v, imm, (funct3 == 3'd5) && funct7[5]);
            flags_d.reg_write = 1'b1;
            if (funct3 == 3'd1)      flags_d.illegal = (funct7 != 7'b0000000);
            else if (funct3 == 3'd5) flags_d.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
         end
         OPC_OP: begin
            flags_d.reg_write = 1'b1;
            if (funct7 == 7'b0000000) begin
               result_d = alu(funct3, rs1_v, rs2_v, 1'b0);
            end else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)) begin
               result_d = alu(funct3, rs1_v, rs2_v, 1'b1);
`ifdef RV32M_MUL_EN
            end else if (funct7 == 7'b0000001 && !funct3[2]) begin
               case (funct3[1:0])
                  2'd0:    result_d = prod_uu[31:0];
                  2'd1:    result_d = prod_ss[63:32];
                  2'd2:    result_d = prod_su[63:32];
                  default: result_d = prod_uu[63:32];
               endcase
`endif
            end else begin
               flags_d.illegal = 1'b1;
            end
         end
         default: flags_d.illegal = 1'b1;
      endcase
      if (flags_d.illegal) begin
         flags_d  = '0;
         flags_d.illegal = 1'b1;
         result_d = '0;
         dest_d   = '0;
      end
      if (rd == 5'd0) flags_d.reg_write = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         flags_q  <= '0;
         result_q <= '0;
         dest_q   <= '0;
         wdest_q  <= '0;
      end else if (state == ST_EXEC) begin
         flags_q  <= flags_d;
         result_q <= result_d;
         dest_q   <= dest_d;
         wdest_q  <= rd;
      end
   end

   assign result            = result_q;
   assign mem_read_enabled  = flags_q.mem_read;
   assign mem_write_enabled = flags_q.mem_write;
   assign reg_write_enabled = flags_q.reg_write;
   assign reg_write_dest    = wdest_q;
   assign is_jump_enabled   = flags_q.jump;
   assign jump_dest         = dest_q;
   assign illegal           = flags_q.illegal;

endmodule

// File: tb/tb_rv32i_decode_exec.sv
// tb/tb_rv32i_decode_exec.sv - directed-vector bench for rv32i_decode_exec.
module tb_rv32i_decode_exec;

   logic        clk = 1'b0;
   logic        rstn;
   logic [2:0]  state;
   logic [31:0] instr_raw, pc, w_data;
   logic        w_enable;
   logic [4:0]  w_addr;
   logic [4:0]  rd, rs1, rs2, reg_write_dest;
   logic [31:0] imm, rs1_v, rs2_v, result, jump_dest;
   logic [2:0]  mem_funct3;
   logic        mem_read_enabled, mem_write_enabled, reg_write_enabled, is_jump_enabled, illegal;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rv32i_decode_exec dut (
      .clk(clk), .rstn(rstn), .state(state), .instr_raw(instr_raw), .pc(pc),
      .w_enable(w_enable), .w_addr(w_addr), .w_data(w_data),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .rs1_v(rs1_v), .rs2_v(rs2_v),
      .mem_funct3(mem_funct3), .result(result),
      .mem_read_enabled(mem_read_enabled), .mem_write_enabled(mem_write_enabled),
      .reg_write_enabled(reg_write_enabled), .reg_write_dest(reg_write_dest),
      .is_jump_enabled(is_jump_enabled), .jump_dest(jump_dest), .illegal(illegal)
   );

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      w_enable = 1'b1; w_addr = a; w_data = d;
      @(negedge clk);
      w_enable = 1'b0;
   endtask

   task automatic decode_only(input logic [31:0] ins);
      @(negedge clk);
      state = 3'd1; instr_raw = ins;
      @(negedge clk);
      state = 3'd0; instr_raw = 32'hDEAD_BEEF;
   endtask

   // DECODE, EXEC, then park in MEM with a junk word so held outputs are checked
   task automatic run(input logic [31:0] ins, input logic [31:0] p);
      @(negedge clk);
      state = 3'd1; instr_raw = ins;
      @(negedge clk);
      state = 3'd2; pc = p; instr_raw = 32'hDEAD_BEEF;
      @(negedge clk);
      state = 3'd3; pc = 32'hFFFF_FFF0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      vectors++;
      if ({mem_read_enabled, mem_write_enabled, reg_write_enabled, is_jump_enabled, illegal} !== 5'b0) begin
         miscompares++; $display("FAIL reset_flags got %b want 00000",
            {mem_read_enabled, mem_write_enabled, reg_write_enabled, is_jump_enabled, illegal});
      end
      vectors++;
      if (result !== 32'd0 || imm !== 32'd0 || reg_write_dest !== 5'd0 || jump_dest !== 32'd0) begin
         miscompares++; $display("FAIL reset_values result=%h imm=%h dest=%0d jd=%h want all 0",
            result, imm, reg_write_dest, jump_dest);
      end
      decode_only(32'h0002_8013);
      vectors++;
      if (rs1 !== 5'd5 || rs1_v !== 32'd0) begin
         miscompares++; $display("FAIL reset_read_x5 rs1=%0d rs1_v=%h want 5/0", rs1, rs1_v);
      end
   endtask

   task automatic test_write_read;
      @(negedge clk);
      w_enable = 1'b1; w_addr = 5'd5; w_data = 32'h0000_00AB;
      #1;
      vectors++;
      if (rs1_v !== 32'd0) begin
         miscompares++; $display("FAIL same_cycle_old got %h want 00000000", rs1_v);
      end
      @(negedge clk);
      w_enable = 1'b0;
      vectors++;
      if (rs1_v !== 32'h0000_00AB) begin
         miscompares++; $display("FAIL next_cycle_new got %h want 000000ab", rs1_v);
      end
   endtask

   task automatic test_alu;
      wr(5'd1, 32'd5);
      wr(5'd2, 32'd3);
      run(32'h0020_81B3, 32'h0);
      vectors++;
      if (result !== 32'd8 || reg_write_enabled !== 1'b1 || reg_write_dest !== 5'd3 || illegal !== 1'b0) begin
         miscompares++; $display("FAIL add result=%h rw=%b dest=%0d ill=%b want 8/1/3/0",
            result, reg_write_enabled, reg_write_dest, illegal);
      end
      run(32'h4020_8233, 32'h0);
      vectors++;
      if (result !== 32'd2 || reg_write_enabled !== 1'b1 || reg_write_dest !== 5'd4) begin
         miscompares++; $display("FAIL sub result=%h rw=%b dest=%0d want 2/1/4",
            result, reg_write_enabled, reg_write_dest);
      end
      run(32'h0020_8033, 32'h0);
      vectors++;
      if (result !== 32'd8 || reg_write_enabled !== 1'b0) begin
         miscompares++; $display("FAIL add_rd0 result=%h rw=%b want 8/0", result, reg_write_enabled);
      end
   endtask

   task automatic test_imm;
      decode_only(32'h0050_0093);
      vectors++;
      if (imm !== 32'd5 || rs1 !== 5'd0 || rd !== 5'd1) begin
         miscompares++; $display("FAIL addi_decode imm=%h rs1=%0d rd=%0d want 5/0/1", imm, rs1, rd);
      end
      run(32'h0050_0093, 32'h0);
      vectors++;
      if (result !== 32'd5 || reg_write_enabled !== 1'b1) begin
         miscompares++; $display("FAIL addi_exec result=%h rw=%b want 5/1", result, reg_write_enabled);
      end
      run(32'h1234_53B7, 32'h0);
      vectors++;
      if (result !== 32'h1234_5000 || reg_write_dest !== 5'd7 || reg_write_enabled !== 1'b1) begin
         miscompares++; $display("FAIL lui result=%h dest=%0d rw=%b want 12345000/7/1",
            result, reg_write_dest, reg_write_enabled);
      end
   endtask

   task automatic test_branch;
      run(32'h0000_0463, 32'h100);
      vectors++;
      if (is_jump_enabled !== 1'b1 || jump_dest !== 32'h108 || reg_write_enabled !== 1'b0) begin
         miscompares++; $display("FAIL beq_taken jump=%b dest=%h rw=%b want 1/108/0",
            is_jump_enabled, jump_dest, reg_write_enabled);
      end
      wr(5'd1, 32'd5);
      run(32'h0020_8463, 32'h100);
      vectors++;
      if (is_jump_enabled !== 1'b0 || reg_write_enabled !== 1'b0) begin
         miscompares++; $display("FAIL beq_not_taken jump=%b rw=%b want 0/0", is_jump_enabled, reg_write_enabled);
      end
      run(32'h0100_00EF, 32'h100);
      vectors++;
      if (is_jump_enabled !== 1'b1 || jump_dest !== 32'h110 || result !== 32'h104 || reg_write_enabled !== 1'b1) begin
         miscompares++; $display("FAIL jal jump=%b dest=%h result=%h rw=%b want 1/110/104/1",
            is_jump_enabled, jump_dest, result, reg_write_enabled);
      end
   endtask

   task automatic test_load;
      wr(5'd1, 32'h0000_1000);
      run(32'h0040_A283, 32'h0);
      vectors++;
      if (mem_read_enabled !== 1'b1 || mem_write_enabled !== 1'b0 || result !== 32'h1004 ||
          mem_funct3 !== 3'd2 || reg_write_dest !== 5'd5 || reg_write_enabled !== 1'b1) begin
         miscompares++; $display("FAIL lw mr=%b mw=%b result=%h f3=%0d dest=%0d rw=%b want 1/0/1004/2/5/1",
            mem_read_enabled, mem_write_enabled, result, mem_funct3, reg_write_dest, reg_write_enabled);
      end
   endtask

   task automatic test_mul;
      logic [31:0] exp_r;
      logic        exp_ill;
      wr(5'd1, 32'd5);
      run(32'h0220_81B3, 32'h0);
`ifdef RV32M_MUL_EN
      exp_r = 32'd15; exp_ill = 1'b0;
`else
      exp_r = 32'd0;  exp_ill = 1'b1;
`endif
      vectors++;
      if (result !== exp_r || illegal !== exp_ill) begin
         miscompares++; $display("FAIL mul result=%h ill=%b want %h/%b", result, illegal, exp_r, exp_ill);
      end
   endtask

   task automatic test_x0_illegal;
      wr(5'd0, 32'hFFFF_FFFF);
      decode_only(32'h0000_0013);
      vectors++;
      if (rs1_v !== 32'd0) begin
         miscompares++; $display("FAIL x0_write got %h want 00000000", rs1_v);
      end
      run(32'hFFFF_FFFF, 32'h100);
      vectors++;
      if (illegal !== 1'b1 || mem_read_enabled !== 1'b0 || mem_write_enabled !== 1'b0 ||
          reg_write_enabled !== 1'b0 || is_jump_enabled !== 1'b0 || result !== 32'd0) begin
         miscompares++; $display("FAIL illegal ill=%b mr=%b mw=%b rw=%b j=%b result=%h want 1/0/0/0/0/0",
            illegal, mem_read_enabled, mem_write_enabled, reg_write_enabled, is_jump_enabled, result);
      end
   endtask

   task automatic test_reset_mid;
      run(32'h1234_53B7, 32'h0);
      @(negedge clk);
      state = 3'd1; instr_raw = 32'h0020_81B3;
      @(negedge clk);
      state = 3'd2; rstn = 1'b1;
      @(negedge clk);
      rstn = 1'b0; state = 3'd3;
      vectors++;
      if (result !== 32'd0 || reg_write_enabled !== 1'b0 || reg_write_dest !== 5'd0 || rd !== 5'd0) begin
         miscompares++; $display("FAIL mid_reset result=%h rw=%b dest=%0d rd=%0d want 0/0/0/0",
            result, reg_write_enabled, reg_write_dest, rd);
      end
      decode_only(32'h0020_81B3);
      vectors++;
      if (rs1_v !== 32'd0 || rs2_v !== 32'd0) begin
         miscompares++; $display("FAIL mid_reset_regs rs1_v=%h rs2_v=%h want 0/0", rs1_v, rs2_v);
      end
   endtask

   initial begin
      state = 3'd0; instr_raw = 32'd0; pc = 32'd0;
      w_enable = 1'b0; w_addr = 5'd0; w_data = 32'd0; rstn = 1'b1;
      test_reset();
      test_write_read();
      test_alu();
      test_imm();
      test_branch();
      test_load();
      test_mul();
      test_x0_illegal();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
